// File: rtl/eq_access_ctrl_if.sv
// EQ command definitions and the single-op port bundle
// between the access controller and the 4-way event queue.
package eq_access_pkg;
  localparam logic INSERT_CMD  = 1'b1;
  localparam logic EXTRACT_CMD = 1'b0;
endpackage

interface eq_access_ctrl_if #(
  parameter int data_wd = 32
);
  logic [data_wd-1:0] eq_ev_in;
  logic               eq_op;
  logic               eq_cs;
  logic [data_wd-1:0] eq_ev_out;
  logic               eq_dv;
  logic               eq_full;
  logic               eq_empty;
  logic               eq_busy_rd;
  logic               eq_busy_wr;

  modport master (
    output eq_ev_in,
    output eq_op,
    output eq_cs,
    input  eq_ev_out,
    input  eq_dv,
    input  eq_full,
    input  eq_empty,
    input  eq_busy_rd,
    input  eq_busy_wr
  );

  modport slave (
    input  eq_ev_in,
    input  eq_op,
    input  eq_cs,
    output eq_ev_out,
    output eq_dv,
    output eq_full,
    output eq_empty,
    output eq_busy_rd,
    output eq_busy_wr
  );
endinterface

// File: rtl/eq_access_ctrl.sv
// Event-queue access arbiter: round-robin inserters,
// low-priority extract with a starvation bound.
module eq_access_ctrl
  import eq_access_pkg::*;
#(
  parameter int data_wd    = 32,
  parameter int N_INS      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_INS-1:0]         ins_req,
  input  logic [N_INS*data_wd-1:0] ins_ev,
  output logic [N_INS-1:0]         ins_ack,
  input  logic                     ext_req,
  output logic                     ext_ack,
  output logic [data_wd-1:0]       ext_ev,
  output logic                     busy,
  eq_access_ctrl_if.master         eq
);

  localparam int PW = (N_INS > 1) ? $clog2(N_INS) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] S_MAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t state_q, state_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic op_ins_q, op_ins_d;

  logic [N_INS-1:0]   ins_ack_d;
  logic               ext_ack_d;
  logic               cs_d;
  logic               op_d;
  logic [data_wd-1:0] ev_in_d;
  logic [data_wd-1:0] ext_ev_d;

  logic          ins_ok;
  logic          ext_ok;
  logic          gnt_found;
  logic [PW-1:0] gnt_idx;

  assign ins_ok = (ins_req != '0)
                & ~eq.eq_full
                & ~eq.eq_busy_wr;
  assign ext_ok = ext_req
                & eq.eq_dv
                & ~eq.eq_empty
                & ~eq.eq_busy_rd;

  // first requester at or after rr_q, wrapping
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < N_INS; k++) begin
      int j;
      j = (int'(rr_q) + k) % N_INS;
      if (!gnt_found && ins_req[j]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    starve_d  = starve_q;
    op_ins_d  = op_ins_q;
    ins_ack_d = '0;
    ext_ack_d = 1'b0;
    cs_d      = 1'b0;
    op_d      = eq.eq_op;
    ev_in_d   = eq.eq_ev_in;
    ext_ev_d  = ext_ev;
    unique case (state_q)
      IDLE: begin
        if (ext_ok && (!ins_ok || starve_q == S_MAX)) begin
          cs_d      = 1'b1;
          op_d      = EXTRACT_CMD;
          ext_ev_d  = eq.eq_ev_out;
          ext_ack_d = 1'b1;
          starve_d  = '0;
          op_ins_d  = 1'b0;
          state_d   = ISSUE;
        end else if (ins_ok && gnt_found) begin
          cs_d      = 1'b1;
          op_d      = INSERT_CMD;
          ev_in_d   = ins_ev[int'(gnt_idx)*data_wd +: data_wd];
          ins_ack_d[gnt_idx] = 1'b1;
          if (int'(gnt_idx) == N_INS - 1) begin
            rr_d = '0;
          end else begin
            rr_d = gnt_idx + PW'(1);
          end
          if (!ext_ok) begin
            starve_d = '0;
          end else if (starve_q != S_MAX) begin
            starve_d = starve_q + SW'(1);
          end
          op_ins_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (op_ins_q ? !eq.eq_busy_wr : !eq.eq_busy_rd) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      starve_q    <= '0;
      op_ins_q    <= 1'b0;
      ins_ack     <= '0;
      ext_ack     <= 1'b0;
      ext_ev      <= '0;
      busy        <= 1'b0;
      eq.eq_cs    <= 1'b0;
      eq.eq_op    <= EXTRACT_CMD;
      eq.eq_ev_in <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      starve_q    <= starve_d;
      op_ins_q    <= op_ins_d;
      ins_ack     <= ins_ack_d;
      ext_ack     <= ext_ack_d;
      ext_ev      <= ext_ev_d;
      busy        <= (state_d != IDLE);
      eq.eq_cs    <= cs_d;
      eq.eq_op    <= op_d;
      eq.eq_ev_in <= ev_in_d;
    end
  end

endmodule

// File: tb/tb_eq_access_ctrl.sv
// Scoreboard bench for eq_access_ctrl: expected grants
// are queued with stimulus and matched on each ack.
module tb_eq_access_ctrl;
  import eq_access_pkg::*;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]    ins_req;
  logic [NI*DW-1:0] ins_ev;
  logic [NI-1:0]    ins_ack;
  logic             ext_req;
  logic             ext_ack;
  logic [DW-1:0]    ext_ev;
  logic             busy;

  eq_access_ctrl_if #(.data_wd(DW)) eq ();

  eq_access_ctrl #(
    .data_wd(DW),
    .N_INS(NI),
    .STARVE_MAX(SM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ins_req(ins_req),
    .ins_ev(ins_ev),
    .ins_ack(ins_ack),
    .ext_req(ext_req),
    .ext_ack(ext_ack),
    .ext_ev(ext_ev),
    .busy(busy),
    .eq(eq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    bit            is_ext;
    int            idx;
    logic [DW-1:0] ev;
    int            gap;
  } exp_t;

  exp_t exp_q[$];
  int cyc = 0;
  int last_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && (ins_ack != '0 || ext_ack)) begin
      if (exp_q.size() == 0) begin
        chk("unexp_ack", {59'd0, ext_ack, ins_ack}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("kind", 64'(ext_ack), 64'(e.is_ext));
        chk("onehot", 64'($onehot0(ins_ack)), 64'd1);
        chk("cs", 64'(eq.eq_cs), 64'd1);
        if (e.is_ext) begin
          chk("ext_ev", 64'(ext_ev), 64'(e.ev));
          chk("op_ext", 64'(eq.eq_op), 64'(EXTRACT_CMD));
        end else begin
          chk("ins_ack", 64'(ins_ack), 64'(1 << e.idx));
          chk("ev_in", 64'(eq.eq_ev_in), 64'(e.ev));
          chk("op_ins", 64'(eq.eq_op), 64'(INSERT_CMD));
        end
        if (e.gap > 0) chk("gap", 64'(cyc - last_cyc), 64'(e.gap));
      end
      last_cyc = cyc;
    end else if (rst && eq.eq_cs) begin
      chk("cs_noack", 64'd1, 64'd0);
    end
  end

  task automatic push_ins(input int idx, input int gap);
    exp_t e;
    e.is_ext = 1'b0;
    e.idx    = idx;
    e.ev     = ins_ev[idx*DW +: DW];
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_ext(input logic [DW-1:0] ev,
                          input int gap);
    exp_t e;
    e.is_ext = 1'b1;
    e.idx    = 0;
    e.ev     = ev;
    e.gap    = gap;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_tmo", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic idle_wait(input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_tmo", 64'(busy), 64'd0);
  endtask

  task automatic eq_defaults();
    eq.eq_ev_out  = '0;
    eq.eq_dv      = 1'b0;
    eq.eq_full    = 1'b0;
    eq.eq_empty   = 1'b1;
    eq.eq_busy_rd = 1'b0;
    eq.eq_busy_wr = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst     = 1'b0;
    ins_req = '0;
    ext_req = 1'b0;
    eq_defaults();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ins_ack"}, 64'(ins_ack), 64'd0);
    chk({tag, "_ext_ack"}, 64'(ext_ack), 64'd0);
    chk({tag, "_cs"}, 64'(eq.eq_cs), 64'd0);
    chk({tag, "_op"}, 64'(eq.eq_op), 64'(EXTRACT_CMD));
    chk({tag, "_ev_in"}, 64'(eq.eq_ev_in), 64'd0);
    chk({tag, "_ext_ev"}, 64'(ext_ev), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    ins_req = '0;
    ext_req = 1'b0;
    eq_defaults();
    for (int i = 0; i < NI; i++) begin
      ins_ev[i*DW +: DW] = 32'hA000_0000 | 32'(i + 1);
    end

    // reset state
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b1;
    @(negedge clk);

    // round robin, all inserters held
    push_ins(0, 0);
    push_ins(1, 3);
    push_ins(2, 3);
    push_ins(3, 3);
    push_ins(0, 3);
    ins_req = 4'b1111;
    drain(60);
    ins_req = '0;
    idle_wait(20);

    // reset in WAIT: rr_ptr is 1, so only req 0 wraps
    push_ins(0, 0);
    ins_req = 4'b0001;
    drain(20);
    ins_req = '0;
    eq.eq_busy_wr = 1'b1;
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    #1 rst = 1'b0;
    #1 chk_reset_outs("async");
    @(negedge clk);
    rst = 1'b1;
    eq.eq_busy_wr = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    push_ins(2, 0);
    ins_req = 4'b0100;
    drain(20);
    ins_req = '0;
    idle_wait(20);

    // full back-pressure
    reset_dut();
    ins_ev[2*DW +: DW] = 32'h0000_2222;
    eq.eq_full    = 1'b1;
    eq.eq_dv      = 1'b1;
    eq.eq_empty   = 1'b0;
    eq.eq_ev_out  = 32'h0000_0777;
    push_ext(32'h0000_0777, 0);
    ins_req = 4'b0100;
    ext_req = 1'b1;
    drain(20);
    ext_req = 1'b0;
    repeat (8) @(negedge clk);
    push_ins(2, 0);
    eq.eq_full = 1'b0;
    drain(20);
    ins_req = '0;
    idle_wait(20);

    // starvation bound
    reset_dut();
    eq.eq_dv     = 1'b1;
    eq.eq_empty  = 1'b0;
    eq.eq_ev_out = 32'h0000_0B0B;
    for (int k = 0; k < SM; k++) begin
      push_ins(k % NI, (k == 0) ? 0 : 3);
    end
    push_ext(32'h0000_0B0B, 3);
    ins_req = 4'b1111;
    ext_req = 1'b1;
    drain(80);
    ext_req = 1'b0;
    push_ins(0, 3);
    drain(20);
    ins_req = '0;
    idle_wait(20);

    // extract data, then long busy_rd
    reset_dut();
    eq.eq_dv     = 1'b1;
    eq.eq_empty  = 1'b0;
    eq.eq_ev_out = 32'h0000_0010;
    push_ext(32'h0000_0010, 0);
    ext_req = 1'b1;
    drain(20);
    ext_req = 1'b0;
    eq.eq_busy_rd = 1'b1;
    eq.eq_ev_out  = 32'h0000_0099;
    ins_req = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("busy_hold", 64'(busy), 64'd1);
    end
    push_ins(0, 0);
    eq.eq_busy_rd = 1'b0;
    drain(20);
    ins_req = '0;
    idle_wait(20);
    chk("ext_ev_hold", 64'(ext_ev), 64'h10);

    // empty queue: extract stalls, insert proceeds
    reset_dut();
    ext_req = 1'b1;
    repeat (20) @(negedge clk);
    chk("empty_idle", 64'(busy), 64'd0);
    push_ins(0, 0);
    ins_req = 4'b0001;
    drain(20);
    ins_req = '0;
    idle_wait(20);
    eq.eq_ev_out = 32'h0000_0042;
    eq.eq_dv     = 1'b1;
    eq.eq_empty  = 1'b0;
    push_ext(32'h0000_0042, 0);
    drain(20);
    ext_req = 1'b0;
    idle_wait(20);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
